// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory-port arbiter: stall bit positions and patterns,
// FSM state encodings and the grant owner type.
package mem_port_arbiter_pkg;

    localparam int STALL_PC_BIT  = 0;
    localparam int STALL_IF_BIT  = 1;
    localparam int STALL_ID_BIT  = 2;
    localparam int STALL_EX_BIT  = 3;
    localparam int STALL_MEM_BIT = 4;
    localparam int STALL_WB_BIT  = 5;

    localparam logic [5:0] STALL_NONE     = 6'b000000;
    localparam logic [5:0] STALL_FETCH    = 6'(1 << STALL_PC_BIT) | 6'(1 << STALL_IF_BIT);
    localparam logic [5:0] STALL_LOAD_USE = STALL_FETCH | 6'(1 << STALL_ID_BIT);
    localparam logic [5:0] STALL_MEM      = STALL_LOAD_USE | 6'(1 << STALL_EX_BIT)
                                          | 6'(1 << STALL_MEM_BIT);

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_XFER  = 2'd1,
        ST_MEM_XFER = 2'd2,
        ST_RESP     = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Counts non-acknowledged bus cycles; last_o flags the final allowed cycle,
// expire_o holds once the limit has been reached.
module timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic last_o,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o   = en_i && (cnt_q == LIMIT_M1);
    assign expire_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory bus between fetch and load/store, with alternating
// priority, bus timeout, fetch discard on flush, and the pipeline stall vector.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_be_i,
    output logic        mem_ack_o,
    output logic [31:0] mem_rdata_o,
    input  logic        id_stallreq_i,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_err_o,
    output logic [5:0]  stall_o
);

    arb_state_t  state_q, state_d;
    grant_t      owner_q, owner_d;
    grant_t      last_q, last_d;
    logic        discard_q, discard_d;
    logic        bus_req_q, bus_req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        in_xfer, to_last, to_expire;

    assign in_xfer = (state_q == ST_IF_XFER) || (state_q == ST_MEM_XFER);

    timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (!in_xfer),
        .en_i     (in_xfer && bus_req_q && !bus_ack_i),
        .last_o   (to_last),
        .expire_o (to_expire)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        discard_d = discard_q;
        bus_req_d = bus_req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        case (state_q)
            ST_IDLE: begin
                discard_d = 1'b0;
                // On contention MEM wins unless it was the last one served.
                if (mem_req_i && (!if_req_i || (last_q == GNT_IF))) begin
                    state_d   = ST_MEM_XFER;
                    owner_d   = GNT_MEM;
                    bus_req_d = 1'b1;
                    we_d      = mem_we_i;
                    addr_d    = mem_addr_i;
                    wdata_d   = mem_wdata_i;
                    be_d      = mem_be_i;
                end else if (if_req_i) begin
                    state_d   = ST_IF_XFER;
                    owner_d   = GNT_IF;
                    bus_req_d = 1'b1;
                    we_d      = 1'b0;
                    addr_d    = if_addr_i;
                    wdata_d   = ZeroWord;
                    be_d      = 4'hF;
                end
            end
            ST_IF_XFER, ST_MEM_XFER: begin
                if (bus_req_q && bus_ack_i) begin
                    rdata_d   = bus_rdata_i;
                    bus_req_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (to_expire) begin
                    rdata_d = ZeroWord;
                    state_d = ST_RESP;
                end else if (to_last) begin
                    // Drop the request with the error pulse; RESP follows next cycle.
                    err_d     = 1'b1;
                    bus_req_d = 1'b0;
                end
                if ((state_q == ST_IF_XFER) && flush_i) begin
                    discard_d = 1'b1;
                end
            end
            ST_RESP: begin
                last_d    = owner_q;
                discard_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= GNT_IF;
            last_q    <= GNT_IF;
            discard_q <= 1'b0;
            bus_req_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= ZeroWord;
            wdata_q   <= ZeroWord;
            be_q      <= 4'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            discard_q <= discard_d;
            bus_req_q <= bus_req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    // A flush landing in the RESP cycle itself must still hide the fetch ack.
    assign if_ack_o    = !rst && (state_q == ST_RESP) && (owner_q == GNT_IF)
                         && !discard_q && !flush_i;
    assign mem_ack_o   = !rst && (state_q == ST_RESP) && (owner_q == GNT_MEM);
    assign if_rdata_o  = if_ack_o  ? rdata_q : ZeroWord;
    assign mem_rdata_o = mem_ack_o ? rdata_q : ZeroWord;

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign bus_be_o    = be_q;
    assign bus_err_o   = err_q;

    always_comb begin
        stall_o = STALL_NONE;
        if (rst) begin
            stall_o = STALL_NONE;
        end else if (mem_req_i && !mem_ack_o) begin
            stall_o = STALL_MEM;
        end else if (id_stallreq_i) begin
            stall_o = STALL_LOAD_USE;
        end else if (if_req_i && !if_ack_o && !flush_i) begin
            stall_o = STALL_FETCH;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed cycle-table bench for mem_port_arbiter (TIMEOUT=4) plus a bounded-wait
// fetch sequence and a reset-state check.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i, if_ack_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        mem_req_i, mem_we_i, mem_ack_o;
    logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
    logic [3:0]  mem_be_i;
    logic        id_stallreq_i, flush_i;
    logic        bus_req_o, bus_we_o, bus_ack_i, bus_err_o;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_be_o;
    logic [5:0]  stall_o;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_be_i(mem_be_i), .mem_ack_o(mem_ack_o),
        .mem_rdata_o(mem_rdata_o), .id_stallreq_i(id_stallreq_i), .flush_i(flush_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_ack_i(bus_ack_i),
        .bus_rdata_i(bus_rdata_i), .bus_err_o(bus_err_o), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ifr;
        logic [31:0] ifa;
        logic        mr, mw;
        logic [31:0] ma, mwd;
        logic [3:0]  mb;
        logic        ids, fl, ak;
        logic [31:0] rd;
        logic        x_req, x_we;
        logic [31:0] x_addr, x_wdata;
        logic [3:0]  x_be;
        logic        x_ifack;
        logic [31:0] x_ifrd;
        logic        x_mack;
        logic [31:0] x_mrd;
        logic        x_err;
        logic [5:0]  x_stall;
    } vec_t;

    localparam logic        H = 1'b1;
    localparam logic        L = 1'b0;
    localparam logic [31:0] Z = 32'h0;
    localparam logic [3:0]  B0 = 4'h0;
    localparam logic [3:0]  BF = 4'hF;
    localparam logic [5:0]  S0 = 6'b000000;
    localparam logic [5:0]  SF = 6'b000011;
    localparam logic [5:0]  SL = 6'b000111;
    localparam logic [5:0]  SM = 6'b011111;

    vec_t tbl[64];
    vec_t cur;
    int   n_rows = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic drv(input logic r, fi, input logic [31:0] fa, input logic mr, mw,
                       input logic [31:0] ma, mwd, input logic [3:0] mb,
                       input logic ids, fl, ak, input logic [31:0] rd);
        cur.rst = r;  cur.ifr = fi; cur.ifa = fa; cur.mr = mr; cur.mw = mw;
        cur.ma = ma;  cur.mwd = mwd; cur.mb = mb; cur.ids = ids; cur.fl = fl;
        cur.ak = ak;  cur.rd = rd;
    endtask

    task automatic expc(input logic rq, we, input logic [31:0] ad, wd, input logic [3:0] be,
                        input logic ia, input logic [31:0] ird, input logic mk,
                        input logic [31:0] mrd, input logic er, input logic [5:0] st);
        cur.x_req = rq; cur.x_we = we; cur.x_addr = ad; cur.x_wdata = wd; cur.x_be = be;
        cur.x_ifack = ia; cur.x_ifrd = ird; cur.x_mack = mk; cur.x_mrd = mrd;
        cur.x_err = er; cur.x_stall = st;
        tbl[n_rows] = cur;
        n_rows++;
    endtask

    task automatic idle_row(input logic [5:0] st);
        expc(L, L, Z, Z, B0, L, Z, L, Z, L, st);
    endtask

    task automatic zero_row();
        drv(L, L, Z, L, L, Z, Z, B0, L, L, L, Z);
        idle_row(S0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_row(input int k);
        vec_t v;
        logic bad;
        v = tbl[k];
        bad = 1'b0;
        if (bus_req_o !== v.x_req || bus_err_o !== v.x_err || if_ack_o !== v.x_ifack ||
            mem_ack_o !== v.x_mack || stall_o !== v.x_stall) bad = 1'b1;
        if (v.x_req && (bus_we_o !== v.x_we || bus_addr_o !== v.x_addr ||
            bus_wdata_o !== v.x_wdata || bus_be_o !== v.x_be)) bad = 1'b1;
        if (v.x_ifack && if_rdata_o !== v.x_ifrd) bad = 1'b1;
        if (v.x_mack && mem_rdata_o !== v.x_mrd) bad = 1'b1;
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL row%0d: got req=%b we=%b addr=%h wd=%h be=%h ifack=%b ifrd=%h mack=%b mrd=%h err=%b stall=%b; expected req=%b we=%b addr=%h wd=%h be=%h ifack=%b ifrd=%h mack=%b mrd=%h err=%b stall=%b",
                     k, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o, if_ack_o, if_rdata_o,
                     mem_ack_o, mem_rdata_o, bus_err_o, stall_o, v.x_req, v.x_we, v.x_addr,
                     v.x_wdata, v.x_be, v.x_ifack, v.x_ifrd, v.x_mack, v.x_mrd, v.x_err, v.x_stall);
        end
    endtask

    task automatic apply_row(input int k);
        rst = tbl[k].rst; if_req_i = tbl[k].ifr; if_addr_i = tbl[k].ifa;
        mem_req_i = tbl[k].mr; mem_we_i = tbl[k].mw; mem_addr_i = tbl[k].ma;
        mem_wdata_i = tbl[k].mwd; mem_be_i = tbl[k].mb; id_stallreq_i = tbl[k].ids;
        flush_i = tbl[k].fl; bus_ack_i = tbl[k].ak; bus_rdata_i = tbl[k].rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqs, got, lat;

        // reset with live inputs, then idle
        drv(H, H, 32'h100, H, H, 32'h2000, 32'hDEADBEEF, BF, H, L, H, 32'h1); idle_row(S0);
        zero_row();
        // single fetch, ack on the third request cycle
        drv(L, H, 32'h100, L, L, Z, Z, B0, L, L, L, Z);          idle_row(SF);
        drv(L, H, 32'h100, L, L, Z, Z, B0, L, L, L, Z);          expc(H, L, 32'h100, Z, BF, L, Z, L, Z, L, SF);
        drv(L, H, 32'h100, L, L, Z, Z, B0, L, L, L, Z);          expc(H, L, 32'h100, Z, BF, L, Z, L, Z, L, SF);
        drv(L, H, 32'h100, L, L, Z, Z, B0, L, L, H, 32'h00A00093); expc(H, L, 32'h100, Z, BF, L, Z, L, Z, L, SF);
        drv(L, H, 32'h100, L, L, Z, Z, B0, L, L, L, Z);          expc(L, L, Z, Z, B0, H, 32'h00A00093, L, Z, L, S0);
        zero_row();
        // contention: MEM first, then IF, then MEM again
        drv(L, H, 32'h104, H, H, 32'h2000, 32'hDEADBEEF, BF, L, L, L, Z);          idle_row(SM);
        drv(L, H, 32'h104, H, H, 32'h2000, 32'hDEADBEEF, BF, L, L, H, 32'h12345678); expc(H, H, 32'h2000, 32'hDEADBEEF, BF, L, Z, L, Z, L, SM);
        drv(L, H, 32'h104, H, H, 32'h2000, 32'hDEADBEEF, BF, L, L, L, Z);          expc(L, L, Z, Z, B0, L, Z, H, 32'h12345678, L, SF);
        drv(L, H, 32'h104, H, H, 32'h2004, 32'hCAFEF00D, 4'h3, L, L, L, Z);        idle_row(SM);
        drv(L, H, 32'h104, H, H, 32'h2004, 32'hCAFEF00D, 4'h3, L, L, H, 32'h13);    expc(H, L, 32'h104, Z, BF, L, Z, L, Z, L, SM);
        drv(L, H, 32'h104, H, H, 32'h2004, 32'hCAFEF00D, 4'h3, L, L, L, Z);        expc(L, L, Z, Z, B0, H, 32'h13, L, Z, L, SM);
        drv(L, H, 32'h108, H, H, 32'h2004, 32'hCAFEF00D, 4'h3, L, L, L, Z);        idle_row(SM);
        drv(L, H, 32'h108, H, H, 32'h2004, 32'hCAFEF00D, 4'h3, L, L, H, 32'h9);     expc(H, H, 32'h2004, 32'hCAFEF00D, 4'h3, L, Z, L, Z, L, SM);
        drv(L, H, 32'h108, H, H, 32'h2004, 32'hCAFEF00D, 4'h3, L, L, L, Z);        expc(L, L, Z, Z, B0, L, Z, H, 32'h9, L, SF);
        zero_row();
        // load-use hazard alone and under a pending load
        drv(L, L, Z, L, L, Z, Z, B0, H, L, L, Z);                idle_row(SL);
        drv(L, L, Z, H, L, 32'h3000, Z, 4'h1, H, L, L, Z);       idle_row(SM);
        drv(L, L, Z, H, L, 32'h3000, Z, 4'h1, L, L, H, 32'hAB);  expc(H, L, 32'h3000, Z, 4'h1, L, Z, L, Z, L, SM);
        drv(L, L, Z, H, L, 32'h3000, Z, 4'h1, H, L, L, Z);       expc(L, L, Z, Z, B0, L, Z, H, 32'hAB, L, SL);
        zero_row();
        // flush during a fetch: ack swallowed, next fetch granted
        drv(L, H, 32'h200, L, L, Z, Z, B0, L, L, L, Z);          idle_row(SF);
        drv(L, H, 32'h200, L, L, Z, Z, B0, L, H, L, Z);          expc(H, L, 32'h200, Z, BF, L, Z, L, Z, L, S0);
        drv(L, H, 32'h300, L, L, Z, Z, B0, L, L, H, 32'hBAD);    expc(H, L, 32'h200, Z, BF, L, Z, L, Z, L, SF);
        drv(L, H, 32'h300, L, L, Z, Z, B0, L, L, L, Z);          idle_row(SF);
        drv(L, H, 32'h300, L, L, Z, Z, B0, L, L, L, Z);          idle_row(SF);
        drv(L, H, 32'h300, L, L, Z, Z, B0, L, L, H, 32'h11111111); expc(H, L, 32'h300, Z, BF, L, Z, L, Z, L, SF);
        drv(L, H, 32'h300, L, L, Z, Z, B0, L, L, L, Z);          expc(L, L, Z, Z, B0, H, 32'h11111111, L, Z, L, S0);
        zero_row();
        // timeout after 4 unacknowledged request cycles
        drv(L, L, Z, H, L, 32'h4000, Z, BF, L, L, L, 32'hFFFFFFFF); idle_row(SM);
        for (int i = 0; i < 4; i++) begin
            drv(L, L, Z, H, L, 32'h4000, Z, BF, L, L, L, 32'hFFFFFFFF);
            expc(H, L, 32'h4000, Z, BF, L, Z, L, Z, L, SM);
        end
        drv(L, L, Z, H, L, 32'h4000, Z, BF, L, L, L, 32'hFFFFFFFF); expc(L, L, Z, Z, B0, L, Z, L, Z, H, SM);
        drv(L, L, Z, H, L, 32'h4000, Z, BF, L, L, L, 32'hFFFFFFFF); expc(L, L, Z, Z, B0, L, Z, H, Z, L, S0);
        zero_row();
        // reset in the middle of a store, then a stray ack
        drv(L, L, Z, H, H, 32'h5000, 32'h55AA55AA, 4'hC, L, L, L, Z); idle_row(SM);
        drv(L, L, Z, H, H, 32'h5000, 32'h55AA55AA, 4'hC, L, L, L, Z); expc(H, H, 32'h5000, 32'h55AA55AA, 4'hC, L, Z, L, Z, L, SM);
        drv(H, L, Z, H, H, 32'h5000, 32'h55AA55AA, 4'hC, L, L, L, Z); expc(H, H, 32'h5000, 32'h55AA55AA, 4'hC, L, Z, L, Z, L, S0);
        drv(L, L, Z, L, L, Z, Z, B0, L, L, H, 32'h77);            idle_row(S0);
        zero_row();

        rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0; mem_req_i = 1'b0; mem_we_i = 1'b0;
        mem_addr_i = '0; mem_wdata_i = '0; mem_be_i = '0; id_stallreq_i = 1'b0;
        flush_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {22'b0, bus_req_o, bus_we_o, if_ack_o, mem_ack_o, bus_err_o, stall_o}, Z);
        chk("reset_addr", bus_addr_o, Z);
        chk("reset_wdata", bus_wdata_o, Z);
        chk("reset_be", {28'b0, bus_be_o}, Z);
        chk("reset_rdata", if_rdata_o | mem_rdata_o, Z);

        for (int k = 0; k < n_rows; k++) begin
            @(posedge clk);
            #1;
            apply_row(k);
            @(negedge clk);
            check_row(k);
        end

        // fetch with memory answering on its third request cycle, bounded wait
        @(posedge clk);
        #1;
        if_req_i = 1'b1; if_addr_i = 32'h400; bus_rdata_i = 32'hCAFE0400;
        reqs = 0; got = 0; lat = -1;
        for (int c = 0; c < 20 && got == 0; c++) begin
            @(negedge clk);
            if (if_ack_o) begin
                got = 1;
                lat = c;
                chk("seq_rdata", if_rdata_o, 32'hCAFE0400);
            end else begin
                if (bus_req_o) reqs++;
                bus_ack_i = bus_req_o && (reqs == 3);
            end
        end
        if_req_i = 1'b0; bus_ack_i = 1'b0;
        chk("seq_ack_seen", got, 1);
        chk("seq_latency", lat, 4);
        chk("seq_req_cycles", reqs, 3);

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single-ported memory bus between the IF stage (instruction fetch) and the MEM stage (load/store), and produces the pipeline stall vector. The stall vector freezes PC/IF/ID/EX/MEM/WB while an access is outstanding or ID reports a load-use hazard. It sits beside the five-stage pipeline: IF and MEM are requesters, external memory is the target, and every pipeline register consumes `stall_o`.

## Interface
Parameters:
- `TIMEOUT`, default 255: bus cycles to wait for `bus_ack_i` before aborting (1..1023).

Ports. Reset is `rst`, synchronous, active-high.
- `clk` in 1: clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `if_req_i` in 1: fetch request, held until `if_ack_o`
- `if_addr_i` in 32: fetch address
- `if_ack_o` out 1: one-cycle fetch completion pulse
- `if_rdata_o` out 32: fetched word, valid with `if_ack_o`
- `mem_req_i` in 1: load/store request, held until `mem_ack_o`
- `mem_we_i` in 1: 1 = store
- `mem_addr_i` in 32: data address
- `mem_wdata_i` in 32: store data
- `mem_be_i` in 4: byte enables
- `mem_ack_o` out 1: one-cycle data completion pulse
- `mem_rdata_o` out 32: load data, valid with `mem_ack_o`
- `id_stallreq_i` in 1: load-use hazard from ID
- `flush_i` in 1: taken branch; discard in-flight fetch
- `bus_req_o` out 1: memory request
- `bus_we_o` out 1, `bus_addr_o` out 32, `bus_wdata_o` out 32, `bus_be_o` out 4: latched transfer attributes
- `bus_ack_i` in 1: memory completion
- `bus_rdata_i` in 32: memory read data, valid with `bus_ack_i`
- `bus_err_o` out 1: one-cycle timeout pulse
- `stall_o` out 6: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB

## Operation
- FSM states:
  - IDLE
  - IF_XFER
  - MEM_XFER
  - RESP (one cycle, returns ack to the owner).
- IDLE grant rules:
  - If both requests are pending, MEM wins unless the last completed grant was MEM; in that case IF wins (alternating fairness).
  - If only one is pending, it is granted.
  - At grant, the address, we, wdata and be are latched. Fetch latches we=0, be=4'hF.
- XFER: `bus_req_o`=1 and attributes are held stable.
  - On `bus_ack_i`: capture `bus_rdata_i` and go to RESP.
  - On timeout (counter reaches `TIMEOUT` with no ack): pulse `bus_err_o`, go to RESP, and return rdata=32'h0.
- RESP: pulse the owner's ack with the captured data, then go to IDLE. A requester that keeps its req high after the ack cycle is treated as a new access.
- Flush:
  - `flush_i` during IF_XFER, or while in RESP for an IF grant, sets a discard flag. The bus transfer completes normally, but `if_ack_o` is suppressed.
  - The flag clears on entry to IDLE.
  - Flush never aborts a MEM transfer.
- Stall vector (combinational), priority top-down:
  - mem_pend = `mem_req_i` & ~`mem_ack_o` → 6'b011111
  - `id_stallreq_i` → 6'b000111
  - if_pend = `if_req_i` & ~`if_ack_o` & ~`flush_i` → 6'b000011
  - otherwise → 6'b000000
- Reset values:
  - FSM = IDLE, last-grant = IF, discard = 0, counter = 0.
  - All outputs 0, including `stall_o` = 0 (inputs are don't-care during reset).
- Reset mid-transfer: return to IDLE the next cycle and drop `bus_req_o`. A late `bus_ack_i` arriving in IDLE is ignored.

## Timing
- Request seen in IDLE at cycle N → `bus_req_o` is high from N+1.
- `bus_ack_i` at cycle M (M ≥ N+1) → owner ack plus data at M+1 (RESP) → IDLE at M+2 → earliest next `bus_req_o` at M+3.
- Zero-wait memory (ack in the first req cycle) gives 4 cycles per access, back to back.
- Timeout: `bus_err_o` fires in the cycle after `TIMEOUT` consecutive non-acked XFER cycles. The ack follows 1 cycle later.
- `bus_*` outputs are registered. `stall_o` is combinational from the inputs and the registered acks.

## Structure
- Shared package / `define.v` holds:
  - the stall-bit index constants and the 6'b stall patterns
  - the FSM state encodings (2-bit)
  - `ZeroWord`
- One natural sub-module is `timeout_counter` (clear, enable, expire flag, width clog2(TIMEOUT+1)). The FSM, arbitration and stall logic stay in one file.

## Test plan
- IF only, addr 0x100, ack 2 cycles after `bus_req_o` rises, rdata 0x00A00093 → `if_ack_o` with that data exactly 1 cycle after ack; `stall_o`=6'b000011 until the ack.
- IF and MEM requested in the same cycle, store 0xDEADBEEF to 0x2000, be 4'b1111 → MEM granted first, `stall_o`=6'b011111; IF served next; then with both pending again, IF is granted (alternation).
- Load-use: `id_stallreq_i`=1 while idle → `stall_o`=6'b000111; asserted together with mem_pend → 6'b011111.
- `flush_i` pulse during IF_XFER → bus completes, `if_ack_o` never pulses, new fetch is granted afterwards.
- No ack with TIMEOUT=4 → `bus_err_o` pulse after 4 req cycles, then owner ack with rdata 0.
- `rst` asserted mid MEM_XFER → next cycle `bus_req_o`=0, all acks 0, `stall_o`=0, and a late `bus_ack_i` is ignored.
